// File: rtl/div_sched_pkg.sv
// Shared types and helpers for the round-robin divider scheduler.
package div_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/div_sched_divuint.sv
// Sequential restoring unsigned divider: one quotient bit per cycle, done pulses
// WIDTH+1 cycles after enable (one cycle after enable when the divisor is zero).
module divuint #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] rem,
    output logic             dbz,
    output logic             done
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] div_r;
    logic [CNT_W-1:0] cnt_r;
    logic             busy_r;
    logic             done_r;
    logic             dbz_r;
    logic [WIDTH:0]   shift_s;
    logic [WIDTH:0]   diff_s;

    // Trial subtraction of the divisor from the shifted partial remainder.
    always_comb begin
        shift_s = {rem_r, quo_r[WIDTH-1]};
        diff_s  = shift_s - {1'b0, div_r};
    end

    // Operand load and one restoring step per cycle while busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            quo_r  <= '0;
            rem_r  <= '0;
            div_r  <= '0;
            cnt_r  <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            dbz_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (enable && !busy_r) begin
                if (b == '0) begin
                    dbz_r  <= 1'b1;
                    done_r <= 1'b1;
                    quo_r  <= '0;
                    rem_r  <= '0;
                end else begin
                    dbz_r  <= 1'b0;
                    quo_r  <= a;
                    rem_r  <= '0;
                    div_r  <= b;
                    cnt_r  <= CNT_W'(WIDTH);
                    busy_r <= 1'b1;
                end
            end else if (busy_r) begin
                // Borrow bit clear means the divisor fit: keep the difference.
                if (!diff_s[WIDTH]) begin
                    rem_r <= diff_s[WIDTH-1:0];
                    quo_r <= {quo_r[WIDTH-2:0], 1'b1};
                end else begin
                    rem_r <= shift_s[WIDTH-1:0];
                    quo_r <= {quo_r[WIDTH-2:0], 1'b0};
                end
                cnt_r <= cnt_r - CNT_W'(1);
                if (cnt_r == CNT_W'(1)) begin
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                end else begin
                    busy_r <= 1'b1;
                end
            end else begin
                busy_r <= 1'b0;
            end
        end
    end

    assign quotient = quo_r;
    assign rem      = rem_r;
    assign dbz      = dbz_r;
    assign done     = done_r;

endmodule

// File: rtl/div_sched.sv
// Round-robin scheduler sharing one divuint among NREQ requesters; one
// operation in flight, results held until the next response.
module div_sched
    import div_sched_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int NREQ  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ*WIDTH-1:0]      a_flat,
    input  logic [NREQ*WIDTH-1:0]      b_flat,
    output logic [NREQ-1:0]            ack,
    output logic [NREQ-1:0]            rsp_valid,
    output logic [WIDTH-1:0]           rsp_quotient,
    output logic [WIDTH-1:0]           rsp_rem,
    output logic                       rsp_dbz,
    output logic                       busy,
    output logic [idx_w(NREQ)-1:0]     grant_id
);
    localparam int IDX_W = idx_w(NREQ);
    localparam logic [NREQ-1:0] ONE = NREQ'(1'b1);

    state_t            state_r;
    logic [IDX_W-1:0]  ptr_r;
    logic [IDX_W-1:0]  grant_r;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;
    logic              en_r;
    logic [NREQ-1:0]   ack_r;
    logic [NREQ-1:0]   rsp_valid_r;
    logic [WIDTH-1:0]  q_r;
    logic [WIDTH-1:0]  rem_r;
    logic              dbz_r;
    logic              busy_r;

    logic [2*NREQ-1:0] dbl_s;
    logic [2*NREQ-1:0] shifted_s;
    logic [IDX_W:0]    shamt_s;
    logic [NREQ-1:0]   rot_s;
    logic              found_s;
    logic [IDX_W-1:0]  pick_s;

    logic [WIDTH-1:0]  div_q_s;
    logic [WIDTH-1:0]  div_rem_s;
    logic              div_dbz_s;
    logic              div_done_s;

    // Rotate req so bit 0 is the requester just after ptr, then take the first hit.
    always_comb begin
        dbl_s     = {req, req};
        shamt_s   = {1'b0, ptr_r} + {{IDX_W{1'b0}}, 1'b1};
        shifted_s = dbl_s >> shamt_s;
        rot_s     = shifted_s[NREQ-1:0];
        found_s   = 1'b0;
        pick_s    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found_s && rot_s[i]) begin
                found_s = 1'b1;
                pick_s  = IDX_W'((int'(ptr_r) + 1 + i) % NREQ);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Scheduler FSM with registered handshake and response outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            ptr_r       <= IDX_W'(NREQ - 1);
            grant_r     <= '0;
            a_r         <= '0;
            b_r         <= '0;
            en_r        <= 1'b0;
            ack_r       <= '0;
            rsp_valid_r <= '0;
            q_r         <= '0;
            rem_r       <= '0;
            dbz_r       <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            ack_r       <= '0;
            rsp_valid_r <= '0;
            en_r        <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (found_s) begin
                        a_r     <= a_flat[pick_s*WIDTH +: WIDTH];
                        b_r     <= b_flat[pick_s*WIDTH +: WIDTH];
                        grant_r <= pick_s;
                        ack_r   <= ONE << pick_s;
                        en_r    <= 1'b1;
                        busy_r  <= 1'b1;
                        state_r <= START;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                START: state_r <= WAIT;
                WAIT: begin
                    if (div_done_s) begin
                        q_r         <= div_dbz_s ? '0 : div_q_s;
                        rem_r       <= div_dbz_s ? '0 : div_rem_s;
                        dbz_r       <= div_dbz_s;
                        rsp_valid_r <= ONE << grant_r;
                        state_r     <= RESP;
                    end else begin
                        state_r     <= WAIT;
                    end
                end
                RESP: begin
                    ptr_r   <= grant_r;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    divuint #(.WIDTH(WIDTH)) u_div (
        .clk      (clk),
        .rst      (~rst_n),
        .enable   (en_r),
        .a        (a_r),
        .b        (b_r),
        .quotient (div_q_s),
        .rem      (div_rem_s),
        .dbz      (div_dbz_s),
        .done     (div_done_s)
    );

    assign ack          = ack_r;
    assign rsp_valid    = rsp_valid_r;
    assign rsp_quotient = q_r;
    assign rsp_rem      = rem_r;
    assign rsp_dbz      = dbz_r;
    assign busy         = busy_r;
    assign grant_id     = grant_r;

endmodule

// File: tb/tb_div_sched.sv
// Self-checking bench for div_sched: directed table, round-robin sequences,
// mid-operation reset and randomized operations against a plain-arithmetic model.
module tb_div_sched;
    localparam int WIDTH = 10;
    localparam int NREQ  = 4;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] a_flat;
    logic [NREQ*WIDTH-1:0] b_flat;
    logic [NREQ-1:0]       ack;
    logic [NREQ-1:0]       rsp_valid;
    logic [WIDTH-1:0]      rsp_quotient;
    logic [WIDTH-1:0]      rsp_rem;
    logic                  rsp_dbz;
    logic                  busy;
    logic [1:0]            grant_id;

    logic [WIDTH-1:0] a_v [NREQ];
    logic [WIDTH-1:0] b_v [NREQ];

    int tests;
    int fails;
    int exp_order [4];

    typedef struct {
        int idx;
        int a;
        int b;
        int q;
        int r;
        int dbz;
    } vec_t;

    vec_t tbl [6];

    div_sched #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .a_flat       (a_flat),
        .b_flat       (b_flat),
        .ack          (ack),
        .rsp_valid    (rsp_valid),
        .rsp_quotient (rsp_quotient),
        .rsp_rem      (rsp_rem),
        .rsp_dbz      (rsp_dbz),
        .busy         (busy),
        .grant_id     (grant_id)
    );

    for (genvar g = 0; g < NREQ; g++) begin : g_pack
        assign a_flat[g*WIDTH +: WIDTH] = a_v[g];
        assign b_flat[g*WIDTH +: WIDTH] = b_v[g];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One isolated operation on an idle DUT with full latency and result checks.
    task automatic do_op(input string name, input int idx, input int a, input int b,
                         input int eq, input int er, input int ed);
        int n;
        bit got;
        @(negedge clk);
        a_v[idx] = WIDTH'(a);
        b_v[idx] = WIDTH'(b);
        req[idx] = 1'b1;
        n = 0;
        got = 1'b0;
        while (n < 20 && !got) begin
            @(negedge clk);
            n++;
            if (ack != '0) got = 1'b1;
        end
        check({name, "_ack_lat"}, n, 1);
        check({name, "_ack"}, {28'd0, ack}, 32'd1 << idx);
        req[idx] = 1'b0;
        a_v[idx] = WIDTH'($urandom);
        b_v[idx] = WIDTH'($urandom);
        if (got) begin
            n = 0;
            got = 1'b0;
            while (n < 40 && !got) begin
                @(negedge clk);
                n++;
                if (rsp_valid != '0) got = 1'b1;
            end
            check({name, "_rsp_lat"}, n, (b == 0) ? 2 : WIDTH + 2);
            check({name, "_rsp_valid"}, {28'd0, rsp_valid}, 32'd1 << idx);
            check({name, "_ack_in_rsp"}, {28'd0, ack}, 32'd0);
            check({name, "_quot"}, {22'd0, rsp_quotient}, eq);
            check({name, "_rem"}, {22'd0, rsp_rem}, er);
            check({name, "_dbz"}, {31'd0, rsp_dbz}, ed);
            check({name, "_grant_id"}, {30'd0, grant_id}, idx);
        end
    endtask

    // Observe several grants; mode 0 drops req after ack, mode 1 holds req1 and re-arms req3.
    task automatic run_window(input string name, input int mode, input int want, input int max_cyc);
        int gcnt;
        int last_ack;
        int idx;
        int qq[$];
        int rq[$];
        int dq[$];
        int iq[$];
        int eq;
        int er;
        int ed;
        int ei;
        gcnt = 0;
        last_ack = 0;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            if (ack != '0 && rsp_valid != '0) begin
                tests++;
                fails++;
                $display("FAIL %s_overlap: ack %b rsp_valid %b both high", name, ack, rsp_valid);
            end
            if (ack != '0) begin
                idx = 0;
                for (int i = 0; i < NREQ; i++) if (ack[i]) idx = i;
                check({name, "_ack_onehot"}, $countones(ack), 1);
                if (gcnt < 4) check({name, "_grant_order"}, idx, exp_order[gcnt]);
                if (gcnt > 0) check({name, "_ack_spacing"}, c - last_ack, WIDTH + 4);
                iq.push_back(idx);
                qq.push_back((b_v[idx] == 0) ? 0 : int'(a_v[idx]) / int'(b_v[idx]));
                rq.push_back((b_v[idx] == 0) ? 0 : int'(a_v[idx]) % int'(b_v[idx]));
                dq.push_back((b_v[idx] == 0) ? 1 : 0);
                gcnt++;
                last_ack = c;
                if (mode == 0 || idx == 3) req[idx] = 1'b0;
                if (gcnt >= want) req = '0;
            end
            if (rsp_valid != '0) begin
                if (iq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL %s_spurious_rsp: rsp_valid %b with nothing outstanding", name, rsp_valid);
                end else begin
                    ei = iq.pop_front();
                    eq = qq.pop_front();
                    er = rq.pop_front();
                    ed = dq.pop_front();
                    check({name, "_rsp_valid"}, {28'd0, rsp_valid}, 32'd1 << ei);
                    check({name, "_quot"}, {22'd0, rsp_quotient}, eq);
                    check({name, "_rem"}, {22'd0, rsp_rem}, er);
                    check({name, "_dbz"}, {31'd0, rsp_dbz}, ed);
                    if (mode == 1 && rsp_valid[3] && gcnt < want) req[3] = 1'b1;
                end
            end
            if (gcnt >= want && iq.size() == 0) break;
        end
        check({name, "_grants"}, gcnt, want);
        check({name, "_outstanding"}, iq.size(), 0);
        req = '0;
    endtask

    initial begin
        int n;
        int seen;
        int idx;
        int a;
        int b;
        tests = 0;
        fails = 0;
        req   = '0;
        for (int i = 0; i < NREQ; i++) begin
            a_v[i] = '0;
            b_v[i] = '0;
        end

        tbl[0] = '{idx: 0, a: 100,  b: 7,    q: 14,   r: 2, dbz: 0};
        tbl[1] = '{idx: 2, a: 55,   b: 0,    q: 0,    r: 0, dbz: 1};
        tbl[2] = '{idx: 2, a: 55,   b: 5,    q: 11,   r: 0, dbz: 0};
        tbl[3] = '{idx: 1, a: 1023, b: 1,    q: 1023, r: 0, dbz: 0};
        tbl[4] = '{idx: 3, a: 5,    b: 1023, q: 0,    r: 5, dbz: 0};
        tbl[5] = '{idx: 0, a: 1023, b: 1023, q: 1,    r: 0, dbz: 0};

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ack", {28'd0, ack}, 0);
        check("rst_rsp_valid", {28'd0, rsp_valid}, 0);
        check("rst_quot", {22'd0, rsp_quotient}, 0);
        check("rst_rem", {22'd0, rsp_rem}, 0);
        check("rst_dbz", {31'd0, rsp_dbz}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_grant_id", {30'd0, grant_id}, 0);
        rst_n = 1'b1;

        // All four requesters at once straight after reset.
        @(negedge clk);
        a_v[0] = 10'd100;  b_v[0] = 10'd7;
        a_v[1] = 10'd999;  b_v[1] = 10'd10;
        a_v[2] = 10'd512;  b_v[2] = 10'd3;
        a_v[3] = 10'd1000; b_v[3] = 10'd33;
        exp_order = '{0, 1, 2, 3};
        req = 4'b1111;
        run_window("all4", 0, 4, 100);

        // Fairness: req1 held, req3 re-asserted after each of its responses.
        @(negedge clk);
        a_v[1] = 10'd200; b_v[1] = 10'd9;
        a_v[3] = 10'd77;  b_v[3] = 10'd6;
        exp_order = '{1, 3, 1, 3};
        req = 4'b1010;
        run_window("fair", 1, 4, 100);

        for (int i = 0; i < 6; i++) begin
            do_op($sformatf("tbl%0d", i), tbl[i].idx, tbl[i].a, tbl[i].b,
                  tbl[i].q, tbl[i].r, tbl[i].dbz);
        end

        // Reset three cycles after ack must abort the operation silently.
        @(negedge clk);
        a_v[0] = 10'd100; b_v[0] = 10'd7;
        req[0] = 1'b1;
        n = 0;
        while (n < 20 && ack == '0) begin
            @(negedge clk);
            n++;
        end
        check("mid_ack_lat", n, 1);
        req[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_ack", {28'd0, ack}, 0);
        check("mid_rst_rsp_valid", {28'd0, rsp_valid}, 0);
        check("mid_rst_quot", {22'd0, rsp_quotient}, 0);
        check("mid_rst_rem", {22'd0, rsp_rem}, 0);
        check("mid_rst_dbz", {31'd0, rsp_dbz}, 0);
        check("mid_rst_busy", {31'd0, busy}, 0);
        check("mid_rst_grant_id", {30'd0, grant_id}, 0);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < WIDTH + 8; c++) begin
            @(negedge clk);
            if (rsp_valid != '0 || busy) seen++;
        end
        check("mid_no_stale", seen, 0);
        do_op("post_rst", 0, 9, 2, 4, 1, 0);

        // Randomized single operations against the arithmetic model.
        for (int t = 0; t < 40; t++) begin
            idx = $urandom_range(0, NREQ - 1);
            a = $urandom_range(0, 1023);
            if ($urandom_range(0, 7) == 0) b = 0;
            else if ($urandom_range(0, 2) == 0) b = $urandom_range(1, 15);
            else b = $urandom_range(1, 1023);
            do_op($sformatf("rnd%0d", t), idx, a, b,
                  (b == 0) ? 0 : a / b, (b == 0) ? 0 : a % b, (b == 0) ? 1 : 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/div_sched.md
# div_sched

Round-robin scheduler that shares one unsigned integer divider among `NREQ` requesters in the timekeeping datapath, such as seconds-to-minutes and minutes-to-hours conversion. Each requester presents a dividend and a divisor. The block grants one request at a time, runs it through a single `divuint` instance and returns quotient, remainder and divide-by-zero status to the granted requester. This replaces one divider per client with one shared divider plus a small FSM.

## Interface
Parameters:
- `WIDTH`, 10, operand and result width, matching the divider.
- `NREQ`, 4, number of requesters, 1..8.

Ports (clock and reset first):
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `req` in NREQ: per-requester request level.
- `a_flat` in NREQ*WIDTH: dividends; requester i uses bits [i*WIDTH +: WIDTH].
- `b_flat` in NREQ*WIDTH: divisors, same packing.
- `ack` out NREQ: one-hot, one-cycle pulse when operands are captured.
- `rsp_valid` out NREQ: one-hot, one-cycle pulse when the result is ready.
- `rsp_quotient` out WIDTH: quotient of the last completed operation.
- `rsp_rem` out WIDTH: remainder of the last completed operation.
- `rsp_dbz` out 1: last operation had divisor 0.
- `busy` out 1: high in any state other than IDLE.
- `grant_id` out IDX_W: index of the current or last grant.

## Operation
- Reset (`rst_n` low at an edge) sets all outputs to 0, the FSM to IDLE and `ptr` to NREQ-1. The divider reset is driven as `~rst_n`.
- FSM states: IDLE, START, WAIT, RESP.
- IDLE: if any `req` bit is high, pick the first asserted index searching from `ptr`+1 with wrap-around.
  - Latch that requester's a/b into internal operand registers.
  - Set `grant_id` and pulse `ack` for that index.
  - Go to START.
  - With no request, stay in IDLE.
- START: assert divider `enable` for exactly one cycle; go to WAIT.
- WAIT: hold until divider `done`.
  - Capture `quotient`, `rem` and `dbz` into the response registers.
  - If `dbz` is set, force quotient and remainder to 0.
  - Go to RESP.
- RESP: pulse `rsp_valid[grant_id]`, set `ptr` to `grant_id`, go to IDLE.
- Requester protocol:
  - Hold `req` high with stable a/b until `ack`.
  - Drop `req` in the cycle after `ack` unless a new operation is wanted.
  - A `req` still high at the next IDLE counts as a new request.
  - Operands may change freely after `ack`; they are already latched.
- Dropping `req` before `ack` withdraws the request with no side effects.
- Response registers hold their values until the next RESP. `grant_id` holds until the next grant.
- `req` asserted while `busy` is high is ignored until IDLE. Requests never queue inside the block.
- `NREQ`=1 degenerates to a simple sequencer. `ptr` and `grant_id` stay at 0.

## Timing
- `req` sampled high in IDLE at edge k:
  - `ack` is high in cycle k+1, together with START and divider `enable`.
  - Normal divide: `rsp_valid` is high in cycle k+1+WIDTH+2.
  - Divide by zero: `rsp_valid` is high in cycle k+3.
- Normal-case derivation:
  - The divider is busy for WIDTH cycles, and `done` goes high WIDTH+1 cycles after `enable`.
  - WAIT captures `done`, then RESP lasts one cycle.
- Back-to-back throughput is one operation per WIDTH+4 cycles: `ack` to `ack` is 14 cycles at WIDTH=10.
- Simultaneous requests: exactly one `ack` per grant. The round-robin guarantees any held request is granted within NREQ operations.
- Reset mid-operation:
  - The next cycle shows all outputs 0 and the FSM in IDLE.
  - No `rsp_valid` is issued for the aborted operation.
  - The divider is cleared as well.
- `rsp_valid` and `ack` are never high in the same cycle.

## Structure
- Shared package `div_sched_pkg` holds:
  - the state encoding constants: IDLE=0, START=1, WAIT=2, RESP=3;
  - the `IDX_W` = max(1, clog2(NREQ)) helper.
- One natural sub-module: the existing `divuint`, instantiated once with `WIDTH`.
- Round-robin selection is a combinational priority search over the rotated `req` vector, inline in this block.

## Test plan
- Single request, WIDTH=10: req0 with a=100, b=7 sampled at edge k.
  - `ack`=0001 in cycle k+1.
  - `rsp_valid`=0001 in cycle k+13, with quotient 14, rem 2, dbz 0.
- All four `req` asserted together after reset and held until `ack`; each requester drops `req` after its `ack`.
  - Grants in order 0, 1, 2, 3, with `ack` pulses 14 cycles apart.
  - Each `rsp_valid` carries that requester's correct result.
- Divide by zero: req2 with a=55, b=0.
  - `rsp_valid`=0100 two cycles after `ack`, with dbz 1 and quotient=rem=0.
  - A following req2 with a=55, b=5 returns quotient 11, rem 0, dbz 0.
- Fairness: req1 held high continuously while req3 re-asserts after each of its responses.
  - Grant sequence is 1, 3, 1, 3; neither requester is starved.
- Reset mid-operation: `rst_n` low three cycles after `ack`.
  - All outputs are 0 next cycle and no stale `rsp_valid` appears.
  - After release, req0 with a=9, b=2 returns quotient 4, rem 1.
- Extremes:
  - a=1023, b=1 returns quotient 1023, rem 0.
  - a=5, b=1023 returns quotient 0, rem 5.
  - a=1023, b=1023 returns quotient 1, rem 0.
